// File: rtl/store_commit_buffer_if.sv
// Store commit buffer bus: LSU enqueue, commit controls,
// and the req/ack write port toward data memory.
interface store_commit_buffer_if;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        fireStore;
    logic        fireStore1;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic        empty;
    logic        cmt_pending;

    modport master (
        output st_valid, st_addr, st_data, st_size,
        output fireStore, fireStore1, flush, mem_ack,
        input  st_ready, mem_req, mem_addr, mem_wdata,
        input  mem_wstrb, empty, cmt_pending
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_size,
        input  fireStore, fireStore1, flush, mem_ack,
        output st_ready, mem_req, mem_addr, mem_wdata,
        output mem_wstrb, empty, cmt_pending
    );
endinterface

// File: rtl/store_commit_buffer.sv
// In-order store buffer: speculative enqueue, commit pointer,
// flush of uncommitted entries, one-at-a-time drain to memory.
module store_commit_buffer #(
    parameter int DEPTH = 8
) (
    input logic clk,
    input logic rst,
    store_commit_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } ent_t;

    typedef enum logic {IDLE, WAIT} state_t;

    ent_t          ent_q [DEPTH];
    ent_t          fmt;
    ent_t          ent_sel;
    logic [PW-1:0] head, cmt, tail;
    logic [PW-1:0] head_inc, cmt_next, count;
    logic [PW-1:0] uncmt, n_cmt;
    state_t        state, state_next;
    logic          enq, load_head, load_next, drop_req;
    logic          req_q;
    logic [31:0]   addr_q, wdata_q;
    logic [3:0]    wstrb_q;

    assign count        = tail - head;
    assign head_inc     = head + PW'(1);
    assign bus.st_ready = (count != PW'(DEPTH));
    assign enq          = bus.st_valid & bus.st_ready & ~bus.flush;

    // Commits may only reach entries already present at the edge.
    assign uncmt    = tail - cmt;
    assign n_cmt    = PW'(bus.fireStore) + PW'(bus.fireStore1);
    assign cmt_next = cmt + ((n_cmt > uncmt) ? uncmt : n_cmt);

    always_comb begin
        fmt.addr = {bus.st_addr[31:2], 2'b00};
        fmt.data = bus.st_data;
        fmt.strb = 4'hF;
        unique case (1'b1)
            (bus.st_size == 2'b00): begin
                fmt.strb = 4'b0001 << bus.st_addr[1:0];
                fmt.data = {4{bus.st_data[7:0]}};
            end
            (bus.st_size == 2'b01): begin
                fmt.strb = 4'b0011 << bus.st_addr[1:0];
                fmt.data = {2{bus.st_data[15:0]}};
            end
            default: begin
                fmt.strb = 4'hF;
                fmt.data = bus.st_data;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (enq) ent_q[tail[AW-1:0]] <= fmt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            cmt  <= '0;
            tail <= '0;
        end else begin
            cmt <= cmt_next;
            if (bus.flush)
                tail <= cmt_next;
            else if (enq)
                tail <= tail + PW'(1);
            if (state == WAIT && bus.mem_ack)
                head <= head_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (head != cmt) state_next = WAIT;
            WAIT: if (bus.mem_ack && head_inc == cmt)
                      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_head = (state == IDLE) && (head != cmt);
        load_next = (state == WAIT) && bus.mem_ack
                    && (head_inc != cmt);
        drop_req  = (state == WAIT) && bus.mem_ack
                    && (head_inc == cmt);
        ent_sel   = load_next ? ent_q[head_inc[AW-1:0]]
                              : ent_q[head[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (load_head || load_next) begin
            req_q   <= 1'b1;
            addr_q  <= ent_sel.addr;
            wdata_q <= ent_sel.data;
            wstrb_q <= ent_sel.strb;
        end else if (drop_req) begin
            req_q <= 1'b0;
        end
    end

    assign bus.mem_req     = req_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.mem_wstrb   = wstrb_q;
    assign bus.empty       = (head == tail);
    assign bus.cmt_pending = (head != cmt) || req_q;
endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed bench for store_commit_buffer with a queue-based
// reference model checked every cycle plus literal spot checks.
module tb_store_commit_buffer;
    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    store_commit_buffer_if bus();

    store_commit_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    exp_t        q[$];
    logic [31:0] wlog[$];
    int          ncmt;
    bit          m_req;
    int          tests;
    int          fails;
    bit          chk_on;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t fmt(input logic [31:0] a,
                                 input logic [31:0] d,
                                 input logic [1:0] sz);
        exp_t e;
        int lane;
        lane = int'(a % 4);
        e.a = a - (a % 4);
        if (sz == 2'd0) begin
            e.s = 4'(1 << lane);
            e.d = {d[7:0], d[7:0], d[7:0], d[7:0]};
        end else if (sz == 2'd1) begin
            e.s = 4'(3 << lane);
            e.d = {d[15:0], d[15:0]};
        end else begin
            e.s = 4'hF;
            e.d = d;
        end
        return e;
    endfunction

    // Advances the model by one clock using the inputs held this cycle.
    task automatic model_update();
        bit ackf, nreq;
        int unc, n, sz;
        if (rst) begin
            q.delete();
            ncmt  = 0;
            m_req = 0;
            return;
        end
        ackf = m_req && bus.mem_ack;
        sz   = q.size();
        unc  = sz - ncmt;
        n    = int'(bus.fireStore) + int'(bus.fireStore1);
        if (n > unc) n = unc;
        if (!m_req)    nreq = (ncmt > 0);
        else if (ackf) nreq = (ncmt - 1 > 0);
        else           nreq = 1;
        if (ackf) begin
            wlog.push_back(q[0].a);
            void'(q.pop_front());
            ncmt--;
        end
        ncmt += n;
        if (bus.flush) begin
            while (q.size() > ncmt) void'(q.pop_back());
        end else if (bus.st_valid && sz < DEPTH) begin
            q.push_back(fmt(bus.st_addr, bus.st_data, bus.st_size));
        end
        m_req = nreq;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_on && !rst) begin
            chk("st_ready", 32'(bus.st_ready), 32'(q.size() != DEPTH));
            chk("empty", 32'(bus.empty), 32'(q.size() == 0));
            chk("cmt_pending", 32'(bus.cmt_pending),
                32'((ncmt > 0) || m_req));
            chk("mem_req", 32'(bus.mem_req), 32'(m_req));
            if (m_req && q.size() > 0) begin
                chk("mem_addr", bus.mem_addr, q[0].a);
                chk("mem_wdata", bus.mem_wdata, q[0].d);
                chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(q[0].s));
            end
        end
    end

    task automatic enq(input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz);
        bus.st_valid = 1'b1;
        bus.st_addr  = a;
        bus.st_data  = d;
        bus.st_size  = sz;
        step();
        bus.st_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        bus.mem_ack = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (q.size() == 0 && !m_req) break;
            step();
        end
        bus.mem_ack = 1'b0;
        chk("drain_done", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] sa, sd;
        logic [3:0]  ss;
        int          writes;
        tests = 0;
        fails = 0;
        chk_on = 0;
        bus.st_valid = 0; bus.st_addr = 0; bus.st_data = 0;
        bus.st_size = 0; bus.fireStore = 0; bus.fireStore1 = 0;
        bus.flush = 0; bus.mem_ack = 0;
        rst = 1;
        repeat (3) step();
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_st_ready", 32'(bus.st_ready), 32'd1);
        chk("rst_cmt_pending", 32'(bus.cmt_pending), 32'd0);
        rst = 0;
        chk_on = 1;
        step();

        // single byte store
        enq(32'h8000_0003, 32'h0000_00AB, 2'd0);
        bus.fireStore = 1;
        step();
        bus.fireStore = 0;
        chk("sb_req_lat", 32'(bus.mem_req), 32'd0);
        step();
        chk("sb_req", 32'(bus.mem_req), 32'd1);
        chk("sb_addr", bus.mem_addr, 32'h8000_0000);
        chk("sb_strb", 32'(bus.mem_wstrb), 32'h8);
        chk("sb_data", bus.mem_wdata, 32'hABAB_ABAB);
        bus.mem_ack = 1;
        step();
        bus.mem_ack = 0;
        chk("sb_pending", 32'(bus.cmt_pending), 32'd0);
        chk("sb_empty", 32'(bus.empty), 32'd1);

        // dual commit, back-to-back drain
        enq(32'h0000_0100, 32'h0000_1234, 2'd1);
        enq(32'h0000_0104, 32'hDEAD_BEEF, 2'd2);
        bus.fireStore = 1;
        bus.fireStore1 = 1;
        step();
        bus.fireStore = 0;
        bus.fireStore1 = 0;
        bus.mem_ack = 1;
        step();
        chk("dc_req0", 32'(bus.mem_req), 32'd1);
        chk("dc_strb0", 32'(bus.mem_wstrb), 32'h3);
        chk("dc_data0", bus.mem_wdata, 32'h1234_1234);
        step();
        chk("dc_req1", 32'(bus.mem_req), 32'd1);
        chk("dc_strb1", 32'(bus.mem_wstrb), 32'hF);
        chk("dc_data1", bus.mem_wdata, 32'hDEAD_BEEF);
        step();
        bus.mem_ack = 0;
        chk("dc_done", 32'(bus.mem_req), 32'd0);
        chk("dc_empty", 32'(bus.empty), 32'd1);

        // flush keeps committed entries only
        for (int i = 0; i < 4; i++)
            enq(32'h200 + 32'(4 * i), 32'(i + 1), 2'd2);
        bus.fireStore = 1;
        bus.fireStore1 = 1;
        step();
        bus.fireStore = 0;
        bus.fireStore1 = 0;
        bus.flush = 1;
        step();
        bus.flush = 0;
        writes = 0;
        bus.mem_ack = 1;
        for (int i = 0; i < 10; i++) begin
            if (bus.mem_req) writes++;
            step();
        end
        bus.mem_ack = 0;
        chk("fl_writes", 32'(writes), 32'd2);
        chk("fl_empty", 32'(bus.empty), 32'd1);
        chk("fl_pending", 32'(bus.cmt_pending), 32'd0);

        // fill, commit, drain; three rounds across the wrap
        for (int r = 0; r < 3; r++) begin
            wlog.delete();
            bus.st_valid = 1;
            bus.st_size = 2'd2;
            for (int i = 0; i < DEPTH + 2; i++) begin
                bus.st_addr = 32'h1000 * 32'(r + 1) + 32'(4 * i);
                bus.st_data = 32'(i + 16 * r);
                step();
            end
            bus.st_valid = 0;
            chk("full_ready", 32'(bus.st_ready), 32'd0);
            bus.fireStore = 1;
            bus.fireStore1 = 1;
            repeat (DEPTH / 2 + 1) step();
            bus.fireStore = 0;
            bus.fireStore1 = 0;
            drain(40);
            chk("wrap_count", 32'(wlog.size()), 32'(DEPTH));
            for (int i = 0; i < DEPTH && i < wlog.size(); i++)
                chk("wrap_order", wlog[i],
                    32'h1000 * 32'(r + 1) + 32'(4 * i));
        end

        // over-commit on an empty buffer
        bus.fireStore = 1;
        step();
        bus.fireStore = 0;
        step();
        chk("oc_req", 32'(bus.mem_req), 32'd0);
        chk("oc_pending", 32'(bus.cmt_pending), 32'd0);
        enq(32'h0000_0040, 32'h0000_0077, 2'd0);
        step();
        step();
        chk("oc_noprecommit", 32'(bus.mem_req), 32'd0);
        bus.fireStore = 1;
        step();
        bus.fireStore = 0;
        drain(10);

        // ack stall keeps the request stable
        enq(32'h0000_ABC8, 32'h55AA_33CC, 2'd2);
        bus.fireStore = 1;
        step();
        bus.fireStore = 0;
        step();
        sa = bus.mem_addr;
        sd = bus.mem_wdata;
        ss = bus.mem_wstrb;
        chk("st_addr", sa, 32'h0000_ABC8);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("st_hold_addr", bus.mem_addr, sa);
            chk("st_hold_data", bus.mem_wdata, sd);
            chk("st_hold_strb", 32'(bus.mem_wstrb), 32'(ss));
            chk("st_not_empty", 32'(bus.empty), 32'd0);
        end
        bus.mem_ack = 1;
        step();
        bus.mem_ack = 0;
        chk("st_released", 32'(bus.mem_req), 32'd0);
        chk("st_empty", 32'(bus.empty), 32'd1);

        // mixed simultaneous enqueue/commit/ack/flush
        for (int i = 0; i < 48; i++) begin
            bus.st_valid   = (i % 3 != 0);
            bus.st_size    = 2'(i % 3);
            bus.st_addr    = 32'h3000 + 32'(16 * i)
                             + ((i % 3 == 0) ? 32'(i % 4) :
                                (i % 3 == 1) ? 32'(2 * (i % 2)) : 32'd0);
            bus.st_data    = 32'h0101_0101 * 32'(i + 1);
            bus.fireStore  = (i % 2 == 0);
            bus.fireStore1 = (i % 5 == 0);
            bus.mem_ack    = (i % 4 != 1);
            bus.flush      = (i == 17) || (i == 30);
            step();
        end
        bus.st_valid = 0;
        bus.flush = 0;
        bus.fireStore1 = 0;
        bus.fireStore = 1;
        bus.mem_ack = 0;
        repeat (DEPTH) step();
        bus.fireStore = 0;
        drain(60);

        chk_on = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/store_commit_buffer.md
# store_commit_buffer

In-order store buffer between the LSU store pipeline and data memory, and downstream of the commit stage. The LSU enqueues address-computed stores speculatively. The commit stage retires them through `fireStore`/`fireStore1`. Committed stores drain one at a time to memory over a req/ack handshake. A pipeline flush discards only uncommitted entries, so retired stores are never lost.

## Interface
- `DEPTH`, 8: entry count; power of two, ≥4.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `st_valid`  in  1  enqueue request from the LSU.
- `st_ready`  out  1  `count != DEPTH`; combinational from registered state.
- `st_addr`  in  32  store virtual/physical address.
- `st_data`  in  32  unshifted store data (LSB-aligned).
- `st_size`  in  2  00 = byte, 01 = half, 10 = word; 11 is never driven.
- `fireStore`  in  1  commit the oldest uncommitted entry.
- `fireStore1`  in  1  commit one more entry (the second commit slot).
- `flush`  in  1  pipeline flush (`ctrl flushReq`).
- `mem_req`  out  1  write request, registered.
- `mem_addr`  out  32  word-aligned address, registered.
- `mem_wdata`  out  32  lane-replicated data, registered.
- `mem_wstrb`  out  4  byte strobes, registered.
- `mem_ack`  in  1  write accepted this cycle; only meaningful while `mem_req` = 1.
- `empty`  out  1  no entries at all.
- `cmt_pending`  out  1  at least one committed entry not yet acknowledged; gates the uncached/sync barrier.

## Operation
- **Storage and pointers.** Circular array with three pointers, each log2(DEPTH)+1 bits wide (the extra bit is the wrap bit):
  - `head`: oldest entry, the drain point.
  - `cmt`: first uncommitted entry.
  - `tail`: next free slot.
  - Invariant: head ≤ cmt ≤ tail (modular). `count` = tail − head.
- **Enqueue.** On `st_valid && st_ready && !flush`, write the entry at `tail`, then `tail++`. Per-entry formatting at enqueue:
  - `wstrb`: byte → `4'b0001 << addr[1:0]`; half → `4'b0011 << addr[1:0]`; word → `4'hF`.
  - `wdata`: byte → {4{d[7:0]}}; half → {2{d[15:0]}}; word → d.
  - Misaligned stores never arrive; the commit stage raises them as exceptions.
- **Commit.**
  - `n = fireStore + fireStore1` (0–2); `cmt += n`, saturated at `tail` (registered value). Excess commits are ignored.
  - `fireStore1` alone (without `fireStore`) commits one entry.
- **Flush.**
  - Same-cycle commits apply first, then `tail <= cmt_next`. Uncommitted entries vanish.
  - Enqueue in the flush cycle is dropped.
  - `head`, the in-flight request, and committed entries are untouched.
- **Drain FSM.**
  - IDLE: if `head != cmt`, load `mem_*` from entry[head], set `mem_req` = 1, go to WAIT.
  - WAIT: hold `mem_*` stable until `mem_ack`. On ack, `head++`. Then:
    - if `head+1 != cmt`, load entry[head+1] and stay in WAIT (back-to-back);
    - otherwise `mem_req <= 0` and go to IDLE.
- **Status outputs.**
  - `cmt_pending = (head != cmt) || mem_req`.
  - `empty = (head == tail)`.

## Timing
- **Reset.** All pointers = 0, FSM = IDLE. Outputs: `mem_req` = 0, `mem_addr`/`mem_wdata`/`mem_wstrb` = 0, `empty` = 1, `st_ready` = 1, `cmt_pending` = 0. Reset mid-transaction abandons the request; the memory side is reset together with this block.
- **Enqueue.** Entry written at edge E; `count`/`st_ready` reflect it from E+1.
- **Commit to memory.** Commit at edge C; `mem_req` rises at edge C+1, so it is visible in the cycle after the commit cycle. Minimum commit-to-request latency is 1 cycle.
- **Drain throughput.** One store per cycle when `mem_ack` is held high (back-to-back).
- **Full buffer.** `st_ready` = 0. A drain ack in the same cycle does not raise `st_ready` until the next cycle.
- **Simultaneous events.**
  - Enqueue + commit + ack in one cycle: all three apply independently.
  - Flush + commit: the commit is honoured.
- **Wrap.** Pointers roll over modulo 2·DEPTH. Full is (tail − head) == DEPTH.

## Test plan
- **Single store.** Enqueue SW addr 0x1000_0006? Not legal; use SB addr 0x8000_0003, data 0x0000_00AB, then `fireStore` → one cycle later `mem_req` = 1, `mem_addr` = 0x8000_0000, `mem_wstrb` = 4'b1000, `mem_wdata` = 0xABABABAB. Ack → `cmt_pending` = 0, `empty` = 1.
- **Dual commit, back-to-back drain.** Enqueue SH 0x100 (data 0x1234) and SW 0x104 (data 0xDEADBEEF). `fireStore` + `fireStore1` in the same cycle. Hold `mem_ack` = 1 → two consecutive request cycles:
  - strb 4'b0011, data 0x12341234;
  - strb 4'hF, data 0xDEADBEEF.
- **Flush preserves committed.** Enqueue 4 stores; commit 2; assert `flush` with `mem_ack` = 0 → exactly 2 writes reach memory; `tail` == `cmt`; `empty` = 1 after both acks.
- **Full and wrap.** Fill DEPTH entries → `st_ready` = 0, and `st_valid` is ignored. Commit and drain all, then repeat 3× → correct FIFO order across the pointer wrap.
- **Over-commit.** `fireStore` with 0 uncommitted entries → `cmt` unchanged, `mem_req` stays 0.
- **Ack stall.** Hold `mem_ack` = 0 for 5 cycles → `mem_addr`/`mem_wdata`/`mem_wstrb` stable throughout; `head` advances only on the ack edge.
